// File: rtl/one_hot_encoder.sv
// One-hot encoder: registers 1 << bin_i on each valid sample, one cycle of latency.
// An index at or beyond ONE_HOT_W encodes to all zeros while valid_o still asserts.
// Optional feature: define ONE_HOT_ENCODER_ERR_EN to add the registered out-of-range flag err_o.
module one_hot_encoder #(
   parameter int unsigned BIN_W     = 5,
   parameter int unsigned ONE_HOT_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid_i,
   input  logic [BIN_W-1:0]     bin_i,
`ifdef ONE_HOT_ENCODER_ERR_EN
   output logic                 err_o,
`endif
   output logic [ONE_HOT_W-1:0] one_hot_o,
   output logic                 valid_o
);

   logic [ONE_HOT_W-1:0] decode;
   logic [ONE_HOT_W-1:0] one_hot_d, one_hot_q;
   logic                 valid_d, valid_q;

   // Compare-per-bit decode: an index outside the output range matches no bit.
   always_comb begin
      decode = '0;
      for (int unsigned k = 0; k < ONE_HOT_W; k++) begin
         decode[k] = (32'(bin_i) == k);
      end
   end

   // Next state: load on a valid sample, otherwise hold the last code.
   always_comb begin
      one_hot_d = one_hot_q;
      valid_d   = valid_i;
      if (valid_i) begin
         one_hot_d = decode;
      end
   end

   // Output registers with synchronous reset; a sample seen during reset is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         one_hot_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         one_hot_q <= one_hot_d;
         valid_q   <= valid_d;
      end
   end

   assign one_hot_o = one_hot_q;
   assign valid_o   = valid_q;

`ifdef ONE_HOT_ENCODER_ERR_EN
   logic err_d, err_q;

   // Out-of-range flag follows each valid sample and holds otherwise.
   always_comb begin
      err_d = err_q;
      if (valid_i) begin
         err_d = (32'(bin_i) >= ONE_HOT_W);
      end
   end

   // Flag register, cleared by reset together with the code.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`endif

endmodule

// File: tb/tb_one_hot_encoder.sv
// Self-checking bench for one_hot_encoder: a 32-wide and a 20-wide instance share stimulus.
// Directed table, full sweep, then a random run against a one-cycle-delay model.
module tb_one_hot_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic [4:0]  bin;
   logic [31:0] oh32;
   logic        v32;
   logic [19:0] oh20;
   logic        v20;
`ifdef ONE_HOT_ENCODER_ERR_EN
   logic        err32;
   logic        err20;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   one_hot_encoder #(.BIN_W(5), .ONE_HOT_W(32)) u_dut32 (
      .clk       (clk),
      .reset     (reset),
      .valid_i   (valid),
      .bin_i     (bin),
`ifdef ONE_HOT_ENCODER_ERR_EN
      .err_o     (err32),
`endif
      .one_hot_o (oh32),
      .valid_o   (v32)
   );

   one_hot_encoder #(.BIN_W(5), .ONE_HOT_W(20)) u_dut20 (
      .clk       (clk),
      .reset     (reset),
      .valid_i   (valid),
      .bin_i     (bin),
`ifdef ONE_HOT_ENCODER_ERR_EN
      .err_o     (err20),
`endif
      .one_hot_o (oh20),
      .valid_o   (v20)
   );

   typedef struct {
      logic        rst;
      logic        vld;
      logic [4:0]  b;
      logic [31:0] e_oh32;
      logic [19:0] e_oh20;
      logic        e_vld;
      logic        e_err20;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs and sample outputs 1 ns after the edge.
   task automatic step(input logic r, input logic v, input logic [4:0] b);
      reset = r;
      valid = v;
      bin   = b;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] e32, input logic [19:0] e20,
                            input logic ev, input logic eerr20);
      check({tag, " oh32"}, oh32, e32);
      check({tag, " oh20"}, {12'h0, oh20}, {12'h0, e20});
      check({tag, " valid32"}, {31'h0, v32}, {31'h0, ev});
      check({tag, " valid20"}, {31'h0, v20}, {31'h0, ev});
`ifdef ONE_HOT_ENCODER_ERR_EN
      check({tag, " err32"}, {31'h0, err32}, 32'h0);
      check({tag, " err20"}, {31'h0, err20}, {31'h0, eerr20});
`endif
      check({tag, " pop32"}, {31'h0, ($countones(oh32) > 1)}, 32'h0);
      check({tag, " pop20"}, {31'h0, ($countones(oh20) > 1)}, 32'h0);
   endtask

   logic [31:0] m32;
   logic [19:0] m20;
   logic        mv;
   logic        merr;

   initial begin
      //         rst   vld   bin    oh32          oh20      vld   err20
      vecs[0]  = '{1'b1, 1'b1, 5'd7,  32'h0000_0000, 20'h00000, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 5'd3,  32'h0000_0008, 20'h00008, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 5'd9,  32'h0000_0008, 20'h00008, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 5'd10, 32'h0000_0400, 20'h00400, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 5'd7,  32'h0000_0000, 20'h00000, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 5'd7,  32'h0000_0000, 20'h00000, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 5'd25, 32'h0200_0000, 20'h00000, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 5'd2,  32'h0200_0000, 20'h00000, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 5'd19, 32'h0008_0000, 20'h80000, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 5'd31, 32'h8000_0000, 20'h00000, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 5'd0,  32'h0000_0001, 20'h00001, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 5'd20, 32'h0010_0000, 20'h00000, 1'b1, 1'b1};
      vecs[12] = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 20'h00000, 1'b0, 1'b0};

      reset = 1'b1;
      valid = 1'b0;
      bin   = '0;
      step(1'b1, 1'b0, 5'd0);
      step(1'b1, 1'b0, 5'd0);
      check_all("reset", 32'h0, 20'h0, 1'b0, 1'b0);

      for (int i = 0; i < 13; i++) begin
         step(vecs[i].rst, vecs[i].vld, vecs[i].b);
         check_all($sformatf("vec%0d", i), vecs[i].e_oh32, vecs[i].e_oh20, vecs[i].e_vld,
                   vecs[i].e_err20);
      end

      // Back-to-back sweep of every index.
      step(1'b1, 1'b0, 5'd0);
      for (int i = 0; i < 32; i++) begin
         logic [31:0] e;
         logic [19:0] e20;
         e   = 32'h1 << i;
         e20 = (i < 20) ? e[19:0] : 20'h0;
         step(1'b0, 1'b1, 5'(i));
         check_all($sformatf("sweep%0d", i), e, e20, 1'b1, (i >= 20));
      end
      step(1'b0, 1'b0, 5'd4);
      check_all("sweep_end", 32'h8000_0000, 20'h0, 1'b0, 1'b1);

      // Random run against a one-cycle-delay reference model.
      m32  = 32'h8000_0000;
      m20  = 20'h0;
      mv   = 1'b0;
      merr = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         logic       r;
         logic       v;
         logic [4:0] b;
         logic [31:0] e;
         r = ($urandom_range(0, 49) == 0);
         v = $urandom_range(0, 1) == 1;
         b = 5'($urandom_range(0, 31));
         if (r) begin
            m32 = '0; m20 = '0; mv = 1'b0; merr = 1'b0;
         end else begin
            mv = v;
            if (v) begin
               e    = 32'h1 << b;
               m32  = e;
               m20  = (b < 5'd20) ? e[19:0] : 20'h0;
               merr = (b >= 5'd20);
            end
         end
         step(r, v, b);
         check_all($sformatf("rand%0d", c), m32, m20, mv, merr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
